// File: rtl/mem_lsu_if.sv
// ============================================================================
//  Module   : mem_lsu_if
//  Purpose  : Data-memory request/acknowledge bus between the memory-stage
//             load/store unit (master) and data memory (slave).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface mem_lsu_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output ack, rdata
    );
endinterface

`default_nettype wire

// File: rtl/mem_lsu.sv
// ============================================================================
//  Module   : mem_lsu
//  Purpose  : Memory-stage load/store unit. Aligns byte lanes, sign/zero
//             extends load data, detects misaligned accesses and stalls EX
//             while a data-memory transaction is outstanding.
//  Options  : MEM_LSU_TIMEOUT_EN - adds a bus-timeout counter (TIMEOUT
//             cycles) that abandons an unacknowledged request and raises
//             excp_bus. Without it excp_bus is tied low.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_lsu #(
    parameter int TIMEOUT = 64
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    // EX stage
    input  wire logic        ex_valid,
    input  wire logic [3:0]  ex_op,
    input  wire logic [31:0] ex_addr,
    input  wire logic [31:0] ex_wdata,
    input  wire logic [4:0]  ex_rd,
    output logic             ex_ready,
    // data memory
    mem_lsu_if.master        dm,
    // write-back / status
    output logic             wb_valid,
    output logic [4:0]       wb_rd,
    output logic [31:0]      wb_data,
    output logic             st_done,
    output logic             excp_misalign,
    output logic             excp_bus,
    output logic [31:0]      excp_addr
);

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    localparam logic [1:0] SZ_NONE = 2'd0;
    localparam logic [1:0] SZ_BYTE = 2'd1;
    localparam logic [1:0] SZ_HALF = 2'd2;
    localparam logic [1:0] SZ_WORD = 2'd3;

    // Reject an out-of-range timeout at elaboration time.
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range_check
        $error("mem_lsu: TIMEOUT must be in 1..255");
    end

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t      state;
    logic        req_q;
    logic        we_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [31:0] addr_q;
    logic [3:0]  op_q;
    logic [4:0]  rd_q;

`ifdef MEM_LSU_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
    logic [7:0]  to_cnt;
`endif

    logic        dec_load;
    logic        dec_store;
    logic [1:0]  dec_size;
    logic        dec_misalign;
    logic [3:0]  dec_be;
    logic [31:0] dec_wdata;
    logic [31:0] ld_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign ex_ready = (state == IDLE);
    assign dm.req   = req_q;
    assign dm.we    = we_q;
    assign dm.addr  = {addr_q[31:2], 2'b00};
    assign dm.be    = be_q;
    assign dm.wdata = wdata_q;

    // Decode the incoming op: direction, access size, lane enables,
    // replicated store data and alignment fault.
    always_comb begin
        dec_load     = 1'b0;
        dec_store    = 1'b0;
        dec_size     = SZ_NONE;
        dec_misalign = 1'b0;
        dec_be       = 4'b0000;
        dec_wdata    = 32'h0;
        case (ex_op)
            OP_LB, OP_LBU: begin dec_load  = 1'b1; dec_size = SZ_BYTE; end
            OP_LH, OP_LHU: begin dec_load  = 1'b1; dec_size = SZ_HALF; end
            OP_LW:         begin dec_load  = 1'b1; dec_size = SZ_WORD; end
            OP_SB:         begin dec_store = 1'b1; dec_size = SZ_BYTE; end
            OP_SH:         begin dec_store = 1'b1; dec_size = SZ_HALF; end
            OP_SW:         begin dec_store = 1'b1; dec_size = SZ_WORD; end
            default:       ;
        endcase
        case (dec_size)
            SZ_BYTE: begin
                dec_be    = 4'b0001 << ex_addr[1:0];
                dec_wdata = {4{ex_wdata[7:0]}};
            end
            SZ_HALF: begin
                dec_misalign = ex_addr[0];
                dec_be       = ex_addr[1] ? 4'b1100 : 4'b0011;
                dec_wdata    = {2{ex_wdata[15:0]}};
            end
            SZ_WORD: begin
                dec_misalign = |ex_addr[1:0];
                dec_be       = 4'b1111;
                dec_wdata    = ex_wdata;
            end
            default: ;
        endcase
    end

    // Pick the addressed lane(s) out of the read word and extend them.
    always_comb begin
        ld_byte = dm.rdata[8*addr_q[1:0] +: 8];
        ld_half = addr_q[1] ? dm.rdata[31:16] : dm.rdata[15:0];
        case (op_q)
            OP_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
            OP_LBU:  ld_data = {24'h0, ld_byte};
            OP_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
            OP_LHU:  ld_data = {16'h0, ld_half};
            default: ld_data = dm.rdata;
        endcase
    end

    // Transaction FSM with registered bus, write-back and exception outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            req_q         <= 1'b0;
            we_q          <= 1'b0;
            be_q          <= 4'b0000;
            wdata_q       <= 32'h0;
            addr_q        <= 32'h0;
            op_q          <= 4'd0;
            rd_q          <= 5'd0;
            wb_valid      <= 1'b0;
            wb_rd         <= 5'd0;
            wb_data       <= 32'h0;
            st_done       <= 1'b0;
            excp_misalign <= 1'b0;
            excp_addr     <= 32'h0;
`ifdef MEM_LSU_TIMEOUT_EN
            excp_bus      <= 1'b0;
            to_cnt        <= 8'd0;
`endif
        end else begin
            // Status outputs are single-cycle pulses.
            wb_valid      <= 1'b0;
            st_done       <= 1'b0;
            excp_misalign <= 1'b0;
`ifdef MEM_LSU_TIMEOUT_EN
            excp_bus      <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (ex_valid && (dec_load || dec_store)) begin
                        if (dec_misalign) begin
                            // Fault without touching memory.
                            excp_misalign <= 1'b1;
                            excp_addr     <= ex_addr;
                        end else begin
                            state   <= REQ;
                            req_q   <= 1'b1;
                            we_q    <= dec_store;
                            be_q    <= dec_be;
                            wdata_q <= dec_wdata;
                            addr_q  <= ex_addr;
                            op_q    <= ex_op;
                            rd_q    <= ex_rd;
`ifdef MEM_LSU_TIMEOUT_EN
                            to_cnt  <= 8'd0;
`endif
                        end
                    end
                end
                REQ: begin
                    if (dm.ack) begin
                        // An ack in the final timeout cycle still completes.
                        state <= IDLE;
                        req_q <= 1'b0;
                        if (we_q) begin
                            st_done <= 1'b1;
                        end else begin
                            wb_valid <= 1'b1;
                            wb_rd    <= rd_q;
                            wb_data  <= ld_data;
                        end
`ifdef MEM_LSU_TIMEOUT_EN
                    end else if (to_cnt == TO_LAST) begin
                        state     <= IDLE;
                        req_q     <= 1'b0;
                        excp_bus  <= 1'b1;
                        excp_addr <= addr_q;
                    end else begin
                        to_cnt <= to_cnt + 8'd1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef MEM_LSU_TIMEOUT_EN
    assign excp_bus = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Memory-stage load/store unit directly downstream of the EX-stage ALU.
- Takes the ALU result as the effective address, plus the store operand and the destination register.
- Performs a request/acknowledge transaction with data memory, including byte-lane alignment, sign/zero extension of load data and misalignment detection.
- Stalls the pipeline (via ex_ready) while a transaction is outstanding.

Parameters:
- TIMEOUT, 64: cycles to wait for dm_ack before a bus error is declared. Used only with MEM_LSU_TIMEOUT_EN. Legal range 1..255.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous reset, active low. Decided: one clock, asynchronous active-low reset.
- ex_valid  in  1  an op is presented this cycle.
- ex_op  in  4  0 NOP, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; codes 9..15 are treated as NOP.
- ex_addr  in  32  effective address (ALU output C).
- ex_wdata  in  32  store operand (rt value).
- ex_rd  in  5  load destination register.
- ex_ready  out  1  unit can accept an op; the pipeline stalls EX while this is low.
- dm_req  out  1  memory request.
- dm_we  out  1  1 = write.
- dm_addr  out  32  word address, {ex_addr[31:2], 2'b00}.
- dm_be  out  4  byte enables, little-endian.
- dm_wdata  out  32  lane-replicated write data.
- dm_ack  in  1  memory completion; single-cycle pulse.
- dm_rdata  in  32  read data, valid while dm_ack is high.
- wb_valid  out  1  one-cycle pulse: load result available.
- wb_rd  out  5  load destination register.
- wb_data  out  32  extended load data.
- st_done  out  1  one-cycle pulse: store acknowledged.
- excp_misalign  out  1  one-cycle pulse: misaligned access.
- excp_bus  out  1  one-cycle pulse: bus timeout. Driven 0 when the feature is absent.
- excp_addr  out  32  faulting address; holds until the next exception.

Behaviour:
- Reset values: every output is 0 except ex_ready, which is 1. State is IDLE and the timeout counter is 0.
- Reset asserted mid-transaction: dm_req drops immediately (asynchronously); the pending op is discarded with no wb_valid or st_done. Memory must tolerate an abandoned request.
- FSM has two states, IDLE and REQ. ex_ready = (state == IDLE).
- IDLE:
  - ex_valid and a NOP-class op: ignored.
  - ex_valid and a misaligned op: no request is made. excp_misalign pulses on the next cycle, excp_addr = ex_addr, and the FSM stays in IDLE. Misaligned means LH/LHU/SH with addr[0] = 1, or LW/SW with addr[1:0] != 0.
  - ex_valid and an aligned memory op: op, address, data and rd are registered and the FSM moves to REQ.
- REQ:
  - dm_req = 1; dm_we, dm_addr, dm_be and dm_wdata are held stable until dm_ack.
  - On dm_ack: loads register the extended data, and wb_valid, wb_rd and wb_data are presented on the next cycle. Stores pulse st_done on the next cycle.
  - The FSM returns to IDLE on the dm_ack edge. A new op may be accepted in the same cycle as the wb_valid pulse.
- Minimum latency: accepted at edge N, dm_req high during cycle N+1; with dm_ack in N+1, wb_valid / st_done in N+2. Throughput is one op per 2 cycles.
- Byte enables, k = addr[1:0]:
  - SB and loads of a byte: be = 1 << k. SB drives dm_wdata = {4{wdata[7:0]}}.
  - Halfword: be = 4'b0011 if addr[1] = 0, else 4'b1100. SH drives dm_wdata = {2{wdata[15:0]}}.
  - Word: be = 4'b1111.
  - Loads drive dm_we = 0 but the same be.
- Load extraction: byte = rdata[8k+7:8k]; halfword = rdata[16*addr[1]+15 : 16*addr[1]]. LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through.
- dm_ack while in IDLE is ignored. dm_rdata is sampled only on dm_ack in REQ.
- ex_valid in REQ is ignored; the pipeline holds the op because ex_ready = 0.
- wb_data and wb_rd hold their last values between pulses.

Optional Feature:
- Macro: MEM_LSU_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to REQ and increments each REQ cycle without dm_ack.
  - When the count reaches TIMEOUT with no ack, dm_req drops on the next edge, excp_bus pulses, excp_addr = the registered address, no wb_valid or st_done is produced, and the FSM returns to IDLE.
  - dm_ack arriving in the same cycle the count hits TIMEOUT wins (a normal completion).
- Undefined: no counter; REQ waits indefinitely and excp_bus is tied to 0.

Test Plan:
- Reset with rst_n = 0, then release → ex_ready = 1; dm_req, wb_valid, st_done and all exceptions are 0.
- LB, addr 0x1003, rd 5; dm_ack with rdata 0x80FF_FF12 on the first REQ cycle → dm_addr 0x1000, be 4'b1000; wb_valid at N+2 with wb_data 0xFFFF_FF80, wb_rd 5.
- LHU at addr 0x2002, rdata 0xBEEF_1234 → be 4'b1100, wb_data 0x0000_BEEF. SH at 0x2002 with wdata 0x0000_ABCD → dm_wdata 0xABCD_ABCD, be 4'b1100, dm_we 1, st_done pulse.
- LW at 0x3001 → no dm_req; excp_misalign pulse, excp_addr 0x0000_3001; ex_ready stays 1.
- SW at 0x4000 with dm_ack delayed 3 cycles → dm_req, address and data stable for 4 cycles; ex_ready low throughout; st_done 1 cycle after ack. Assert rst_n = 0 during a wait → dm_req falls without a clock edge.
- With MEM_LSU_TIMEOUT_EN and TIMEOUT = 4, LW at 0x5000 with no ack → dm_req high 4 cycles, then excp_bus pulse with excp_addr 0x5000; no wb_valid; ex_ready returns to 1.
